// File: rtl/rename_alloc_ctrl_pkg.sv
// Shared types for the rename stage.
//   NUM_REGS / ARCH_REGS : default physical / architectural register counts
//   PW                   : physical register index width
//   preg_t               : physical register index
//   rename_state_t       : rename sequencer state (RUN, RECOVER)
package rv32i_types;

  localparam int unsigned NUM_REGS  = 64;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned PW        = $clog2(NUM_REGS);

  typedef logic [PW-1:0] preg_t;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } rename_state_t;

endpackage

// File: rtl/rename_alloc_ctrl_free_list.sv
// Circular free list of physical registers with flush rollback.
//   clk, rst    : clock, synchronous active-high reset
//   pop         : consume fl_mem[head] this cycle
//   push        : append push_preg at tail (a committed instruction freed it)
//   push_preg   : physical register being returned
//   flush       : roll head back to the committed position
//   head_preg   : physical register at the head (next to allocate)
//   count       : number of free entries, 0..FL_DEPTH
module free_list
  import rv32i_types::*;
#(
  parameter int unsigned FL_DEPTH  = 32,
  parameter int unsigned PW        = 6,
  parameter int unsigned ARCH_REGS = 32,
  localparam int unsigned AW = $clog2(FL_DEPTH),
  localparam int unsigned CW = $clog2(FL_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pop,
  input  logic          push,
  input  logic [PW-1:0] push_preg,
  input  logic          flush,
  output logic [PW-1:0] head_preg,
  output logic [CW-1:0] count
);

  logic [PW-1:0] fl_mem [FL_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] commit_head;
  logic [AW-1:0] tail_nxt;
  logic [AW-1:0] ch_nxt;
  logic [CW-1:0] diff;
  logic [CW-1:0] restore_count;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every committed push also retires one committed pop, so commit_head
  // advances with tail; the restore uses the post-push pointers.
  always_comb begin
    tail_nxt = push ? ptr_inc(tail) : tail;
    ch_nxt   = push ? ptr_inc(commit_head) : commit_head;
    if (tail_nxt >= ch_nxt) begin
      diff = CW'(tail_nxt) - CW'(ch_nxt);
    end else begin
      diff = CW'(tail_nxt) + CW'(FL_DEPTH) - CW'(ch_nxt);
    end
    // diff == 0 (tail == commit_head) yields a full list
    restore_count = CW'(FL_DEPTH) - diff;
  end

  assign head_preg = fl_mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        fl_mem[i] <= PW'(ARCH_REGS + i);
      end
      head        <= '0;
      tail        <= '0;
      commit_head <= '0;
      count       <= CW'(FL_DEPTH);
    end else begin
      if (push) begin
        fl_mem[tail] <= push_preg;
      end
      tail        <= tail_nxt;
      commit_head <= ch_nxt;
      if (flush) begin
        head  <= ch_nxt;
        count <= restore_count;
      end else begin
        if (pop) begin
          head <= ptr_inc(head);
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && count == CW'(FL_DEPTH)))
    else $error("free_list: push into a full free list");
  assert property (@(posedge clk) disable iff (rst) !(pop && !flush && count == '0))
    else $error("free_list: pop from an empty free list");

endmodule

// File: rtl/rename_alloc_ctrl.sv
// Rename-stage sequencer: dequeues one instruction per cycle, allocates a
// physical destination from the free list, stalls on ROB / RS / free-list
// exhaustion, reclaims registers at commit and recovers on flush.
//   iq_valid, iq_ready         : instruction queue head handshake
//   dec_rd_we                  : head instruction writes a nonzero arch rd
//   rob_full, rs_full          : downstream back-pressure
//   alloc_valid, alloc_preg    : dispatch strobe and allocated physical rd
//   rat_we                     : RAT write enable
//   retire_valid, retire_rd_we,
//   retire_old_preg            : commit-time release of the previous mapping
//   flush                      : mispredict / exception flush
//   fl_count                   : free entries
//   busy                       : high while recovering
module rename_alloc_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned NUM_REGS  = rv32i_types::NUM_REGS,
  parameter int unsigned ARCH_REGS = rv32i_types::ARCH_REGS,
  parameter int unsigned FL_DEPTH  = NUM_REGS - ARCH_REGS,
  localparam int unsigned PW = $clog2(NUM_REGS),
  localparam int unsigned CW = $clog2(FL_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iq_valid,
  output logic          iq_ready,
  input  logic          dec_rd_we,
  input  logic          rob_full,
  input  logic          rs_full,
  output logic          alloc_valid,
  output logic [PW-1:0] alloc_preg,
  output logic          rat_we,
  input  logic          retire_valid,
  input  logic          retire_rd_we,
  input  logic [PW-1:0] retire_old_preg,
  input  logic          flush,
  output logic [CW-1:0] fl_count,
  output logic          busy
);

  rename_state_t state;
  logic          go;
  logic          push;
  logic [PW-1:0] head_preg;

  assign push = retire_valid & retire_rd_we;

  // A retire in the same cycle as an empty list is not bypassed: the
  // freed register becomes allocatable on the following cycle.
  always_comb begin
    go = (state == RUN) & iq_valid & ~rob_full & ~rs_full
       & (~dec_rd_we | (fl_count != '0)) & ~flush;
  end

  assign iq_ready    = go;
  assign alloc_valid = go;
  assign rat_we      = go & dec_rd_we;
  assign alloc_preg  = dec_rd_we ? head_preg : '0;
  assign busy        = (state == RECOVER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else if (flush) begin
      state <= RECOVER;
    end else begin
      state <= RUN;
    end
  end

  free_list #(
    .FL_DEPTH (FL_DEPTH),
    .PW       (PW),
    .ARCH_REGS(ARCH_REGS)
  ) u_free_list (
    .clk      (clk),
    .rst      (rst),
    .pop      (rat_we),
    .push     (push),
    .push_preg(retire_old_preg),
    .flush    (flush),
    .head_preg(head_preg),
    .count    (fl_count)
  );

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
module tb_rename_alloc_ctrl;
  import rv32i_types::*;

  localparam int NO_CNT = 63;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iq_valid = 1'b0;
  logic       iq_ready;
  logic       dec_rd_we = 1'b0;
  logic       rob_full = 1'b0;
  logic       rs_full = 1'b0;
  logic       alloc_valid;
  logic [5:0] alloc_preg;
  logic       rat_we;
  logic       retire_valid = 1'b0;
  logic       retire_rd_we = 1'b0;
  logic [5:0] retire_old_preg = '0;
  logic       flush = 1'b0;
  logic [5:0] fl_count;
  logic       busy;

  rename_alloc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .iq_valid       (iq_valid),
    .iq_ready       (iq_ready),
    .dec_rd_we      (dec_rd_we),
    .rob_full       (rob_full),
    .rs_full        (rs_full),
    .alloc_valid    (alloc_valid),
    .alloc_preg     (alloc_preg),
    .rat_we         (rat_we),
    .retire_valid   (retire_valid),
    .retire_rd_we   (retire_rd_we),
    .retire_old_preg(retire_old_preg),
    .flush          (flush),
    .fl_count       (fl_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  rst, iv, we, robf, rsf, rv, rwe, fl;
    preg_t old;
    logic  go, rat, bz;
    preg_t preg;
    int    cnt;   // NO_CNT: count not checked on this vector
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input int r, iv, we, robf, rsf, rv, rwe, old, fl,
                     input int go, rat, preg, cnt, bz);
    vec_t v;
    v.rst = 1'(r);    v.iv = 1'(iv);    v.we = 1'(we);   v.robf = 1'(robf);
    v.rsf = 1'(rsf);  v.rv = 1'(rv);    v.rwe = 1'(rwe); v.old = preg_t'(old);
    v.fl = 1'(fl);    v.go = 1'(go);    v.rat = 1'(rat); v.preg = preg_t'(preg);
    v.cnt = cnt;      v.bz = 1'(bz);
    vecs.push_back(v);
  endtask

  task automatic add_rst(input int cnt);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt, 0);
  endtask

  task automatic add_alloc(input int preg, input int cnt);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, preg, cnt, 0);
  endtask

  task automatic add_idle(input int cnt);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt, 0);
  endtask

  task automatic check(input string nm, input int idx, input int act, input int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    int   waits;

    // Back-to-back allocation, branch, ROB/RS stalls, push+pop
    add_rst(NO_CNT);
    add_rst(32);
    for (int i = 0; i < 3; i++) add_alloc(32 + i, 32 - i);
    add_idle(29);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 29, 0);    // no rd
    add_idle(29);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 35, 29, 0);   // rob_full
    add(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 35, 29, 0);   // rs_full
    add_alloc(35, 29);
    add(0, 0, 0, 0, 0, 1, 0, 11, 0, 0, 0, 0, 28, 0);   // retire without rd
    add(0, 1, 1, 0, 0, 1, 1, 9, 0, 1, 1, 36, 28, 0);   // push + pop
    add_idle(28);

    // Allocate 8, commit 3, flush, recover
    add_rst(NO_CNT);
    add_rst(32);
    for (int i = 0; i < 8; i++) add_alloc(32 + i, 32 - i);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 1, 1, 1 + i, 0, 0, 0, 0, 24 + i, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 40, 27, 0);   // flush
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 35, 32, 1);   // RECOVER
    add_alloc(35, 32);
    add_alloc(36, 31);
    add_idle(30);

    // Exhaustion, retire into an empty list, no bypass
    add_rst(NO_CNT);
    add_rst(32);
    for (int i = 0; i < 32; i++) add_alloc(32 + i, 32 - i);
    add(0, 1, 1, 0, 0, 1, 1, 5, 0, 0, 0, 32, 0, 0);    // stall, retire 5
    add_alloc(5, 1);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 33, 0, 0);    // empty again
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);     // no rd at empty
    add_idle(0);

    // Flush with a same-cycle retire, then a flush during RECOVER
    add_rst(NO_CNT);
    add_rst(32);
    add_alloc(32, 32);
    add_alloc(33, 31);
    add(0, 1, 1, 0, 0, 1, 1, 7, 1, 0, 0, 34, 30, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 33, 32, 1);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 33, 32, 1);
    add_alloc(33, 32);
    add_idle(31);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst             = vecs[k].rst;
      iq_valid        = vecs[k].iv;
      dec_rd_we       = vecs[k].we;
      rob_full        = vecs[k].robf;
      rs_full         = vecs[k].rsf;
      retire_valid    = vecs[k].rv;
      retire_rd_we    = vecs[k].rwe;
      retire_old_preg = vecs[k].old;
      flush           = vecs[k].fl;
      sb.push_back(vecs[k]);
      #2;
      e = sb.pop_front();
      n_vec++;
      check("iq_ready", k, int'(iq_ready), int'(e.go));
      check("alloc_valid", k, int'(alloc_valid), int'(e.go));
      check("rat_we", k, int'(rat_we), int'(e.rat));
      check("alloc_preg", k, int'(alloc_preg), int'(e.preg));
      check("busy", k, int'(busy), int'(e.bz));
      if (e.cnt != NO_CNT) check("fl_count", k, int'(fl_count), e.cnt);
    end

    // Flush recovery length measured with a bounded wait
    @(negedge clk);
    rst = 1'b1; iq_valid = 1'b0; dec_rd_we = 1'b0; retire_valid = 1'b0;
    retire_rd_we = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0; iq_valid = 1'b1; dec_rd_we = 1'b1; flush = 1'b1;
    #2;
    n_vec++;
    check("ready_in_flush", n_vec, int'(iq_ready), 0);
    @(negedge clk);
    flush = 1'b0;
    waits = 0;
    #2;
    while (!iq_ready && waits < 8) begin
      waits++;
      @(negedge clk);
      #2;
    end
    n_vec++;
    check("recover_cycles", n_vec, waits, 1);
    check("recover_preg", n_vec, int'(alloc_preg), 32);
    @(negedge clk);
    iq_valid = 1'b0; dec_rd_we = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rename_alloc_ctrl.md
Name: rename_alloc_ctrl

Overview:
- Sequences the rename stage of the OOO core: dequeues one instruction per cycle from the instruction queue and allocates a physical destination from an internal circular free list.
- Drives the physical rd into the rename translation datapath and the RAT write enable.
- Stalls on ROB, reservation-station or free-list exhaustion.
- Reclaims freed physical registers at commit and rolls the free list back on pipeline flush.

Parameters:
- NUM_REGS, 64, physical register count; PW = $clog2(NUM_REGS).
- ARCH_REGS, 32, architectural register count; pregs 0..ARCH_REGS-1 are initially mapped.
- FL_DEPTH, NUM_REGS-ARCH_REGS, free-list entries (32 at defaults).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- iq_valid  in  1  instruction queue head valid
- iq_ready  out  1  dequeue strobe; head consumed this cycle
- dec_rd_we  in  1  head instruction writes a nonzero arch rd
- rob_full  in  1  ROB cannot accept
- rs_full  in  1  target reservation station cannot accept
- alloc_valid  out  1  instruction renamed/dispatched this cycle
- alloc_preg  out  PW  physical rd for rename datapath; 0 when dec_rd_we=0
- rat_we  out  1  write RAT[arch_rd] <= alloc_preg
- retire_valid  in  1  ROB commits one instruction
- retire_rd_we  in  1  committed instruction allocated a preg
- retire_old_preg  in  PW  previous mapping, returned to free list
- flush  in  1  mispredict/exception flush
- fl_count  out  $clog2(FL_DEPTH+1)  free entries, for debug and perf counters
- busy  out  1  high in RECOVER

Behaviour:
- Storage:
  - fl_mem[FL_DEPTH] of PW bits; pointers head, tail, commit_head, each $clog2(FL_DEPTH) bits, wrapping modulo FL_DEPTH.
  - count holds 0..FL_DEPTH.
- Reset:
  - fl_mem[i] = ARCH_REGS+i; head = tail = commit_head = 0; count = FL_DEPTH (full).
  - State RUN; all outputs 0 except fl_count = FL_DEPTH.
- Dispatch is combinational in RUN:
  - go = iq_valid & ~rob_full & ~rs_full & (~dec_rd_we | count != 0) & ~flush.
  - iq_ready = alloc_valid = go.
  - rat_we = go & dec_rd_we.
  - alloc_preg = fl_mem[head] when dec_rd_we, else 0.
- Pop: head++ and count-- at the edge when rat_we.
- Push: when retire_valid & retire_rd_we, fl_mem[tail] <= retire_old_preg, tail++, count++; commit_head++ in the same cycle.
- Push and pop in the same cycle: count unchanged.
- count==0 with a same-cycle push: no bypass; dispatch stalls one cycle.
- Push when count==FL_DEPTH is illegal; flag it with an assertion.
- States:
  - RUN -> RECOVER on flush.
  - RECOVER -> RUN after exactly one cycle.
- Flush edge:
  - head <= commit_head, counting any same-cycle commit advance.
  - count <= FL_DEPTH - (tail - commit_head) mod FL_DEPTH, adjusted for a same-cycle push; if tail == commit_head the result is FL_DEPTH.
  - Pops in the flush cycle are suppressed because go already has ~flush.
- RECOVER:
  - Outputs are forced low: iq_ready, alloc_valid, rat_we = 0; busy = 1.
  - Retire pushes are still accepted.
  - A flush during RECOVER re-applies the restore and stays one more cycle.
- rst has priority over flush, retire and dispatch.
- Latency: rename/dispatch is zero-cycle (same cycle as iq_valid); freed preg is allocatable the cycle after retire.

Decomposition:
- Shared in rv32i_types: NUM_REGS, ARCH_REGS, preg_t (logic [PW-1:0]), and a rename_state_t enum (RUN, RECOVER).
- One sub-module: free_list, the circular FIFO holding pointers, count and commit_head restore.
- rename_alloc_ctrl keeps the FSM, stall logic and handshakes.

Test Plan:
- Reset, then 3 back-to-back rd-writing instructions, no stalls -> alloc_preg 32, 33, 34 on consecutive cycles; fl_count 29.
- Branch/store with dec_rd_we=0 -> alloc_valid=1, rat_we=0, alloc_preg=0; fl_count unchanged.
- 32 allocations with no retires, then a 33rd -> iq_ready=0, fl_count=0; retire old_preg=5 -> next cycle allocates 5.
- rob_full=1 or rs_full=1 with iq_valid=1 -> iq_ready=0, no pop; deassert -> dispatch resumes with the same preg.
- Allocate 32..39 and commit 32..34 (old 1,2,3), then flush -> next alloc after one RECOVER cycle is 35; fl_count 32-3+3=32.
- Flush coincident with a retire (old_preg=7), and a flush while already in RECOVER -> commit_head includes the push; busy held 2 cycles; no alloc in either cycle.
